alu_cmd_queue: RTL and testbench

Command-issue stage placed directly upstream of `alu_32`. It buffers operand/opcode commands in a small FIFO and presents the head command on `alu_32`'s `A_in`/`B_in`/`ALU_Sel`. It captures the combinational ALU result and flags into a registered output stage with valid/ready flow control. It also keeps a sticky overflow flag for software.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_cmd_queue.sv | 126 ++++++++++++
 tb/tb_alu_cmd_queue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-issue stage.
// Select-code names follow the team's usual ALU opcode map.
package alu_pkg;

   localparam int ALU_SEL_W = 4;
   localparam int ALU_WIDTH = 32;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] a;
      logic [ALU_WIDTH-1:0] b;
      logic [ALU_SEL_W-1:0] sel;
   } alu_cmd_t;

   localparam logic [ALU_SEL_W-1:0] SEL_AND = 4'b0000;
   localparam logic [ALU_SEL_W-1:0] SEL_OR  = 4'b0001;
   localparam logic [ALU_SEL_W-1:0] SEL_ADD = 4'b0010;
   localparam logic [ALU_SEL_W-1:0] SEL_SUB = 4'b0110;
   localparam logic [ALU_SEL_W-1:0] SEL_SLT = 4'b0111;
   localparam logic [ALU_SEL_W-1:0] SEL_NOR = 4'b1100;
   localparam logic [ALU_SEL_W-1:0] SEL_XOR = 4'b1111;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small circular command FIFO with an unregistered head output.
// The caller guarantees no push when full and no pop when empty.
module alu_cmd_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0],
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  entry_t        wr_data,
   output entry_t        head,
   output logic [CW-1:0] count
);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Power-of-two depth: pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; stale entries are never visible once pointers clear.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// Command-issue stage for alu_32: buffers commands, drives the ALU from the
// FIFO head and registers its result/flags behind a valid/ready output.
module alu_cmd_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Cmd_Valid,
   output logic                   Cmd_Ready,
   input  logic [WIDTH-1:0]       Cmd_A,
   input  logic [WIDTH-1:0]       Cmd_B,
   input  logic [ALU_SEL_W-1:0]   Cmd_Sel,
   output logic [WIDTH-1:0]       A_in,
   output logic [WIDTH-1:0]       B_in,
   output logic [ALU_SEL_W-1:0]   ALU_Sel,
   input  logic [WIDTH-1:0]       ALU_Out,
   input  logic                   Carry_Out,
   input  logic                   Zero,
   input  logic                   Overflow,
   output logic                   Res_Valid,
   input  logic                   Res_Ready,
   output logic [WIDTH-1:0]       Res_Data,
   output logic                   Res_Carry,
   output logic                   Res_Zero,
   output logic                   Res_Overflow,
   output logic                   Sticky_Overflow,
   input  logic                   Sticky_Clear,
   output logic [$clog2(DEPTH):0] Count
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Cmd_Ready depends only on occupancy; Res_Valid is purely registered.
   typedef struct packed {
      logic [WIDTH-1:0]     a;
      logic [WIDTH-1:0]     b;
      logic [ALU_SEL_W-1:0] sel;
   } cmd_t;

   cmd_t          wr_cmd, head_cmd;
   logic [CW-1:0] count;
   logic          push, cap, empty;

   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_carry_q, res_carry_d;
   logic             res_zero_q, res_zero_d;
   logic             res_ovf_q, res_ovf_d;
   logic             sticky_q, sticky_d;

   assign wr_cmd    = '{a: Cmd_A, b: Cmd_B, sel: Cmd_Sel};
   assign empty     = (count == '0);
   assign Cmd_Ready = (count < CW'(DEPTH));
   assign push      = Cmd_Valid && Cmd_Ready;
   assign cap       = !empty && (!res_valid_q || Res_Ready);

   alu_cmd_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (cmd_t)
   ) u_fifo (
      .clk     (Clk),
      .rst     (Rst),
      .push    (push),
      .pop     (cap),
      .wr_data (wr_cmd),
      .head    (head_cmd),
      .count   (count)
   );

   // Empty FIFO presents an all-zero command to the ALU.
   assign A_in    = empty ? '0 : head_cmd.a;
   assign B_in    = empty ? '0 : head_cmd.b;
   assign ALU_Sel = empty ? '0 : head_cmd.sel;

   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
      res_zero_d  = res_zero_q;
      res_ovf_d   = res_ovf_q;
      sticky_d    = sticky_q;
      if (cap) begin
         res_valid_d = 1'b1;
         res_data_d  = ALU_Out;
         res_carry_d = Carry_Out;
         res_zero_d  = Zero;
         res_ovf_d   = Overflow;
      end else if (res_valid_q && Res_Ready) begin
         res_valid_d = 1'b0;
      end
      // A new overflow beats a simultaneous clear request.
      if (cap && Overflow) sticky_d = 1'b1;
      else if (Sticky_Clear) sticky_d = 1'b0;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_zero_q  <= 1'b0;
         res_ovf_q   <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
         res_zero_q  <= res_zero_d;
         res_ovf_q   <= res_ovf_d;
         sticky_q    <= sticky_d;
      end
   end

   assign Res_Valid       = res_valid_q;
   assign Res_Data        = res_data_q;
   assign Res_Carry       = res_carry_q;
   assign Res_Zero        = res_zero_q;
   assign Res_Overflow    = res_ovf_q;
   assign Sticky_Overflow = sticky_q;
   assign Count           = count;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomised and directed bench for alu_cmd_queue with a stub ALU and a
// queue-based reference model compared on every falling edge.
module tb_alu_cmd_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam logic [31:0] STUB_VAL = 32'hDFF0FD79;

   logic        Clk, Rst;
   logic        Cmd_Valid, Cmd_Ready;
   logic [31:0] Cmd_A, Cmd_B;
   logic [3:0]  Cmd_Sel;
   logic [31:0] A_in, B_in;
   logic [3:0]  ALU_Sel;
   logic [31:0] ALU_Out;
   logic        Carry_Out, Zero, Overflow;
   logic        Res_Valid, Res_Ready;
   logic [31:0] Res_Data;
   logic        Res_Carry, Res_Zero, Res_Overflow;
   logic        Sticky_Overflow, Sticky_Clear;
   logic [2:0]  Count;

   logic stub_force = 1'b0;
   logic ovf_force  = 1'b0;
   logic ovf_rand   = 1'b0;

   int checks = 0;
   int errors = 0;

   alu_cmd_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .Clk(Clk), .Rst(Rst),
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
      .Cmd_A(Cmd_A), .Cmd_B(Cmd_B), .Cmd_Sel(Cmd_Sel),
      .A_in(A_in), .B_in(B_in), .ALU_Sel(ALU_Sel),
      .ALU_Out(ALU_Out), .Carry_Out(Carry_Out), .Zero(Zero), .Overflow(Overflow),
      .Res_Valid(Res_Valid), .Res_Ready(Res_Ready),
      .Res_Data(Res_Data), .Res_Carry(Res_Carry), .Res_Zero(Res_Zero),
      .Res_Overflow(Res_Overflow),
      .Sticky_Overflow(Sticky_Overflow), .Sticky_Clear(Sticky_Clear),
      .Count(Count)
   );

   // Stub ALU: returns {overflow, zero, carry, out}
   function automatic logic [34:0] stub(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] sel, input logic frc,
                                        input logic ovf_f, input logic ovf_r);
      logic [31:0] out;
      logic c, z, v;
      if (frc) out = STUB_VAL;
      else if (sel == 4'hF) out = 32'h0;
      else out = a ^ {b[30:0], 1'b0} ^ {28'h0, sel};
      c = !frc && (out[0] ^ a[31]);
      z = (out == 32'h0);
      v = ovf_f || (ovf_r && out[5] && out[9]);
      return {v, z, c, out};
   endfunction

   assign {Overflow, Zero, Carry_Out, ALU_Out} =
      stub(A_in, B_in, ALU_Sel, stub_force, ovf_force, ovf_rand);

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending commands as a queue plus the output register.
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sel;
   } mcmd_t;

   mcmd_t       mq[$];
   logic        m_valid = 1'b0, m_c = 1'b0, m_z = 1'b0, m_v = 1'b0, m_sticky = 1'b0;
   logic [31:0] m_data = 32'h0;
   logic        m_cap, m_push;
   logic [34:0] m_r;
   int          m_handshakes = 0;

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mq.delete();
         m_valid = 1'b0; m_data = 32'h0; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
         m_sticky = 1'b0;
      end else begin
         m_cap  = (mq.size() != 0) && (!m_valid || Res_Ready);
         m_push = Cmd_Valid && (mq.size() < DEPTH);
         if (m_valid && Res_Ready) m_handshakes++;
         if (m_cap) begin
            m_r = stub(mq[0].a, mq[0].b, mq[0].sel, stub_force, ovf_force, ovf_rand);
            {m_v, m_z, m_c, m_data} = m_r;
            m_valid = 1'b1;
            mq.delete(0);
         end else if (m_valid && Res_Ready) begin
            m_valid = 1'b0;
         end
         if (m_cap && m_r[34]) m_sticky = 1'b1;
         else if (Sticky_Clear) m_sticky = 1'b0;
         if (m_push) mq.push_back('{a: Cmd_A, b: Cmd_B, sel: Cmd_Sel});
      end
   end

   always @(negedge Clk) begin
      if (!Rst) begin
         chk("count", 64'(Count), 64'(mq.size()));
         chk("cmd_ready", 64'(Cmd_Ready), 64'(mq.size() < DEPTH));
         chk("a_in", 64'(A_in), mq.size() != 0 ? 64'(mq[0].a) : 64'h0);
         chk("b_in", 64'(B_in), mq.size() != 0 ? 64'(mq[0].b) : 64'h0);
         chk("alu_sel", 64'(ALU_Sel), mq.size() != 0 ? 64'(mq[0].sel) : 64'h0);
         chk("res_valid", 64'(Res_Valid), 64'(m_valid));
         chk("res_data", 64'(Res_Data), 64'(m_data));
         chk("res_carry", 64'(Res_Carry), 64'(m_c));
         chk("res_zero", 64'(Res_Zero), 64'(m_z));
         chk("res_ovf", 64'(Res_Overflow), 64'(m_v));
         chk("sticky", 64'(Sticky_Overflow), 64'(m_sticky));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clk);
         Cmd_Valid = 1'b0;
         Sticky_Clear = 1'b0;
         Res_Ready = 1'b1;
      end
   endtask

   task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
      Cmd_Valid = 1'b1;
      Cmd_A = a;
      Cmd_B = b;
      Cmd_Sel = sel;
   endtask

   task automatic single_op(input string tag);
      @(negedge Clk);
      stub_force = 1'b1;
      Res_Ready = 1'b1;
      drive_cmd(32'h086a0c31, 32'hd785f148, 4'b0000);
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      chk({tag, "_a_in"}, 64'(A_in), 64'h086a0c31);
      chk({tag, "_b_in"}, 64'(B_in), 64'hd785f148);
      chk({tag, "_alu_sel"}, 64'(ALU_Sel), 64'h0);
      chk({tag, "_count1"}, 64'(Count), 64'd1);
      chk({tag, "_valid0"}, 64'(Res_Valid), 64'd0);
      @(negedge Clk);
      chk({tag, "_valid1"}, 64'(Res_Valid), 64'd1);
      chk({tag, "_data"}, 64'(Res_Data), 64'hDFF0FD79);
      chk({tag, "_count0"}, 64'(Count), 64'd0);
      stub_force = 1'b0;
   endtask

   logic [3:0]  stream_sel [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                  4'b0111, 4'b1100, 4'b1111, 4'b1111};
   logic [31:0] first_a, first_b, first_res;
   logic [34:0] tmp_r;
   int          hs_start;

   initial begin
      Rst = 1'b1;
      Cmd_Valid = 1'b0; Cmd_A = '0; Cmd_B = '0; Cmd_Sel = '0;
      Res_Ready = 1'b0; Sticky_Clear = 1'b0;

      @(negedge Clk);
      chk("rst_cmd_ready", 64'(Cmd_Ready), 64'd1);
      chk("rst_count", 64'(Count), 64'd0);
      Cmd_Valid = 1'b1;
      @(negedge Clk);
      chk("rst_no_push", 64'(Count), 64'd0);
      chk("rst_res_valid", 64'(Res_Valid), 64'd0);
      Cmd_Valid = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;

      single_op("single");
      idle(2);

      // Fill with output blocked
      @(negedge Clk);
      Res_Ready = 1'b0;
      first_a = $urandom; first_b = $urandom;
      drive_cmd(first_a, first_b, 4'b0010);
      tmp_r = stub(first_a, first_b, 4'b0010, 1'b0, 1'b0, 1'b0);
      first_res = tmp_r[31:0];
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         drive_cmd($urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      @(negedge Clk);
      chk("fill_count4", 64'(Count), 64'd4);
      chk("fill_not_ready", 64'(Cmd_Ready), 64'd0);
      chk("fill_res_data", 64'(Res_Data), 64'(first_res));
      drive_cmd($urandom, $urandom, 4'b0001);
      repeat (2) @(negedge Clk);
      chk("fill_refused", 64'(Count), 64'd4);
      chk("fill_res_stable", 64'(Res_Data), 64'(first_res));
      Cmd_Valid = 1'b0;
      idle(8);

      // Streaming
      hs_start = m_handshakes;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (i > 0) chk("stream_count_le1", 64'(Count <= 3'd1), 64'd1);
         Res_Ready = 1'b1;
         drive_cmd($urandom, $urandom, stream_sel[i]);
      end
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      chk("stream_count_le1", 64'(Count <= 3'd1), 64'd1);
      repeat (3) @(negedge Clk);
      chk("stream_results", 64'(m_handshakes - hs_start), 64'd8);

      // Wrap-around rounds
      for (int r = 0; r < 3; r++) begin
         @(negedge Clk);
         Res_Ready = 1'b0;
         drive_cmd($urandom, $urandom, 4'($urandom_range(0, 15)));
         for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            drive_cmd($urandom, $urandom, 4'($urandom_range(0, 15)));
         end
         @(negedge Clk);
         Cmd_Valid = 1'b0;
         chk("wrap_count3", 64'(Count), 64'd3);
         idle(6);
      end

      // Sticky overflow
      @(negedge Clk);
      Sticky_Clear = 1'b1;
      @(negedge Clk);
      Sticky_Clear = 1'b0;
      chk("sticky_clr0", 64'(Sticky_Overflow), 64'd0);
      ovf_force = 1'b1;
      drive_cmd($urandom, $urandom, 4'b0010);
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      @(negedge Clk);
      chk("sticky_set", 64'(Sticky_Overflow), 64'd1);
      chk("sticky_res_ovf", 64'(Res_Overflow), 64'd1);
      ovf_force = 1'b0;
      idle(3);
      chk("sticky_persist", 64'(Sticky_Overflow), 64'd1);
      chk("sticky_drained", 64'(Res_Valid), 64'd0);
      @(negedge Clk);
      ovf_force = 1'b1;
      drive_cmd($urandom, $urandom, 4'b0110);
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      Sticky_Clear = 1'b1;
      @(negedge Clk);
      Sticky_Clear = 1'b0;
      chk("sticky_set_wins", 64'(Sticky_Overflow), 64'd1);
      ovf_force = 1'b0;
      idle(2);
      @(negedge Clk);
      Sticky_Clear = 1'b1;
      @(negedge Clk);
      Sticky_Clear = 1'b0;
      chk("sticky_clear_alone", 64'(Sticky_Overflow), 64'd0);

      // Random traffic
      ovf_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk);
         Cmd_Valid = ($urandom_range(0, 2) != 0);
         Cmd_A = $urandom;
         Cmd_B = $urandom;
         Cmd_Sel = 4'($urandom_range(0, 15));
         Res_Ready = ($urandom_range(0, 3) != 0);
         Sticky_Clear = ($urandom_range(0, 15) == 0);
      end
      ovf_rand = 1'b0;
      idle(8);

      // Reset mid-stream
      @(negedge Clk);
      Res_Ready = 1'b0;
      ovf_force = 1'b1;
      drive_cmd($urandom, $urandom, 4'b0111);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         if (i == 1) ovf_force = 1'b0;
         drive_cmd($urandom, $urandom, 4'b1100);
      end
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      chk("mid_count3", 64'(Count), 64'd3);
      chk("mid_valid1", 64'(Res_Valid), 64'd1);
      chk("mid_sticky1", 64'(Sticky_Overflow), 64'd1);
      #2 Rst = 1'b1;
      #1;
      chk("mid_rst_count", 64'(Count), 64'd0);
      chk("mid_rst_valid", 64'(Res_Valid), 64'd0);
      chk("mid_rst_a_in", 64'(A_in), 64'd0);
      chk("mid_rst_b_in", 64'(B_in), 64'd0);
      chk("mid_rst_sel", 64'(ALU_Sel), 64'd0);
      chk("mid_rst_sticky", 64'(Sticky_Overflow), 64'd0);
      chk("mid_rst_data", 64'(Res_Data), 64'd0);
      @(negedge Clk);
      Rst = 1'b0;
      single_op("post_rst");
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
